mem_access_unit: RTL and testbench



---
 rtl/mau_pkg.sv | 38 +++
 rtl/mau_lane_steer.sv | 73 +++++++
 rtl/mem_access_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// ---------------------------------------------------------------------------
// mau_pkg
// Shared definitions for the memory access unit: access size encodings,
// read/write direction constants, the handshake FSM state encoding and the
// alignment rule used to reject requests before a bus cycle is started.
// ---------------------------------------------------------------------------
package mau_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RELEASE = 2'd2
    } mau_state_e;

    // low_addr holds the lane-select address bits zero-extended to 3 bits;
    // word_mask has a 1 for every lane-select bit of the configured bus.
    function automatic logic mau_misaligned(input logic [1:0] size,
                                            input logic [2:0] low_addr,
                                            input logic [2:0] word_mask);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = low_addr[0];
            SZ_WORD: bad = |(low_addr & word_mask);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mau_lane_steer.sv
// ---------------------------------------------------------------------------
// mau_lane_steer
// Purely combinational little-endian lane logic for the memory access unit.
//   size        in  access size (byte / halfword / word / illegal)
//   lane        in  addressed byte lane (address modulo LANES)
//   sign_ext    in  1 = sign-extend narrow reads, 0 = zero-extend
//   wdata       in  right-aligned write data
//   rd_raw      in  raw data from the memory bus
//   wdata_lanes out write data replicated across every lane
//   byte_en     out active-high lane enables for the access
//   rd_ext      out addressed lane(s) extracted and extended to DATA_W
// ---------------------------------------------------------------------------
module mau_lane_steer
    import mau_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]                    size,
    input  logic [$clog2(DATA_W/8)-1:0]   lane,
    input  logic                          sign_ext,
    input  logic [DATA_W-1:0]             wdata,
    input  logic [DATA_W-1:0]             rd_raw,
    output logic [DATA_W-1:0]             wdata_lanes,
    output logic [DATA_W/8-1:0]           byte_en,
    output logic [DATA_W-1:0]             rd_ext
);

    localparam int LANES  = DATA_W / 8;
    localparam int LANE_W = $clog2(LANES);

    logic [LANE_W-1:0] half_lane;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;

    // Replicating narrow write data into every lane means memory only has
    // to honour BYTE_EN; no shifter is needed on the write path.
    always_comb begin
        wdata_lanes = wdata;
        byte_en     = '0;
        case (size)
            SZ_BYTE: begin
                wdata_lanes = {LANES{wdata[7:0]}};
                byte_en     = LANES'(1) << lane;
            end
            SZ_HALF: begin
                wdata_lanes = {(LANES/2){wdata[15:0]}};
                byte_en     = LANES'(3) << lane;
            end
            SZ_WORD: begin
                wdata_lanes = wdata;
                byte_en     = '1;
            end
            default: begin
                wdata_lanes = wdata;
                byte_en     = '0;
            end
        endcase
    end

    // The halfword select forces lane bit 0 low so the part-select always
    // stays inside the bus even when a misaligned address is presented.
    always_comb begin
        half_lane = lane & ~(LANE_W'(1));
        rd_byte   = rd_raw[{lane, 3'b000} +: 8];
        rd_half   = rd_raw[{half_lane, 3'b000} +: 16];
        case (size)
            SZ_BYTE: rd_ext = {{(DATA_W-8){sign_ext & rd_byte[7]}}, rd_byte};
            SZ_HALF: rd_ext = {{(DATA_W-16){sign_ext & rd_half[15]}}, rd_half};
            default: rd_ext = rd_raw;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// MAR/MBR memory path with an MFA/MFC four-phase handshake, byte/halfword/
// word accesses, lane enables and read extension.
// Optional build macro: MAU_TIMEOUT_EN adds an MFC watchdog that aborts an
// access after TIMEOUT_CYC cycles (0 disables it even when built).
//   Clk, Reset   in  clock, synchronous active-high reset
//   req, rw      in  request from control unit, 1=read 0=write
//   size         in  00 byte, 01 halfword, 10 word, 11 illegal
//   sign_ext     in  read extension select
//   addr, wdata  in  byte address, right-aligned write data
//   busy         out unit not idle
//   done, err    out one-cycle completion / error pulses
//   rdata        out extended read result (MBR)
//   MEMADD       out registered address (MAR)
//   MEMDAT_OUT   out lane-steered write data
//   MEMDAT_IN    in  memory read data
//   MFA / MFC    out/in handshake
//   READ_WRITE   out direction, stable while MFA is high
//   BYTE_EN      out lane enables
// ---------------------------------------------------------------------------
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  req,
    input  logic                  rw,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [DATA_W-1:0]     rdata,
    output logic [ADDR_W-1:0]     MEMADD,
    output logic [DATA_W-1:0]     MEMDAT_OUT,
    input  logic [DATA_W-1:0]     MEMDAT_IN,
    output logic                  MFA,
    input  logic                  MFC,
    output logic                  READ_WRITE,
    output logic [DATA_W/8-1:0]   BYTE_EN
);

    localparam int         LANES     = DATA_W / 8;
    localparam int         LANE_W    = $clog2(LANES);
    localparam logic [2:0] WORD_MASK = 3'(LANES - 1);

    mau_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   memadd_q, memadd_d;
    logic [DATA_W-1:0]   memdat_out_q, memdat_out_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [LANES-1:0]    byte_en_q, byte_en_d;
    logic                rw_q, rw_d;
    logic [1:0]          size_q, size_d;
    logic                sign_ext_q, sign_ext_d;
    logic                mfa_q, mfa_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [1:0]          steer_size;
    logic [LANE_W-1:0]   steer_lane;
    logic [DATA_W-1:0]   steer_wdata;
    logic [LANES-1:0]    steer_byte_en;
    logic [DATA_W-1:0]   steer_rdata;
    logic                misaligned;
    logic                timeout_hit;

    // While idle the steering logic looks at the incoming request so the
    // bus outputs can be latched on acceptance; once a cycle is running it
    // looks at the latched request so the read can be extracted on MFC.
    assign steer_size = (state_q == ST_IDLE) ? size : size_q;
    assign steer_lane = (state_q == ST_IDLE) ? addr[LANE_W-1:0]
                                             : memadd_q[LANE_W-1:0];
    assign misaligned = mau_misaligned(size, 3'(addr[LANE_W-1:0]), WORD_MASK);

    mau_lane_steer #(
        .DATA_W (DATA_W)
    ) u_lane_steer (
        .size        (steer_size),
        .lane        (steer_lane),
        .sign_ext    (sign_ext_q),
        .wdata       (wdata),
        .rd_raw      (MEMDAT_IN),
        .wdata_lanes (steer_wdata),
        .byte_en     (steer_byte_en),
        .rd_ext      (steer_rdata)
    );

`ifdef MAU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Counts ACCESS cycles without MFC; the abort fires on the edge at which
    // the count would reach TIMEOUT_CYC, so MFA is high for exactly that
    // many cycles.
    always_comb begin
        wait_cnt_d  = wait_cnt_q;
        timeout_hit = 1'b0;
        if (state_q == ST_IDLE) begin
            wait_cnt_d = '0;
        end else if (state_q == ST_ACCESS && !MFC) begin
            if (TIMEOUT_CYC > 0 && wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                timeout_hit = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Handshake FSM: accept or reject in IDLE, wait for MFC in ACCESS, then
    // wait for MFC to drop in RELEASE. done/err are single-cycle pulses.
    always_comb begin
        state_d      = state_q;
        memadd_d     = memadd_q;
        memdat_out_d = memdat_out_q;
        rdata_d      = rdata_q;
        byte_en_d    = byte_en_q;
        rw_d         = rw_q;
        size_d       = size_q;
        sign_ext_d   = sign_ext_q;
        mfa_d        = mfa_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (misaligned) begin
                        err_d = 1'b1;
                    end else begin
                        memadd_d     = addr;
                        rw_d         = rw;
                        size_d       = size;
                        sign_ext_d   = sign_ext;
                        byte_en_d    = steer_byte_en;
                        memdat_out_d = steer_wdata;
                        mfa_d        = 1'b1;
                        state_d      = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (MFC) begin
                    mfa_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_RELEASE;
                    if (rw_q == RW_READ) begin
                        rdata_d = steer_rdata;
                    end
                end else if (timeout_hit) begin
                    mfa_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!MFC) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                mfa_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            memadd_q     <= '0;
            memdat_out_q <= '0;
            rdata_q      <= '0;
            byte_en_q    <= '0;
            rw_q         <= RW_READ;
            size_q       <= SZ_BYTE;
            sign_ext_q   <= 1'b0;
            mfa_q        <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            memadd_q     <= memadd_d;
            memdat_out_q <= memdat_out_d;
            rdata_q      <= rdata_d;
            byte_en_q    <= byte_en_d;
            rw_q         <= rw_d;
            size_q       <= size_d;
            sign_ext_q   <= sign_ext_d;
            mfa_q        <= mfa_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign rdata      = rdata_q;
    assign MEMADD     = memadd_q;
    assign MEMDAT_OUT = memdat_out_q;
    assign MFA        = mfa_q;
    assign READ_WRITE = rw_q;
    assign BYTE_EN    = byte_en_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Self-checking bench for mem_access_unit (ADDR_W=8, DATA_W=32 defaults).
// Expected bus values and read results come from a byte-arithmetic model of
// the access rules; the bench plays the memory side of the handshake.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int LANES  = DATA_W / 8;

    logic               Clk;
    logic               Reset;
    logic               req;
    logic               rw;
    logic [1:0]         size;
    logic               sign_ext;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic               busy;
    logic               done;
    logic               err;
    logic [DATA_W-1:0]  rdata;
    logic [ADDR_W-1:0]  MEMADD;
    logic [DATA_W-1:0]  MEMDAT_OUT;
    logic [DATA_W-1:0]  MEMDAT_IN;
    logic               MFA;
    logic               MFC;
    logic               READ_WRITE;
    logic [LANES-1:0]   BYTE_EN;

    int checks   = 0;
    int failures = 0;
    logic [DATA_W-1:0] model_rdata;

    mem_access_unit #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (15)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .req        (req),
        .rw         (rw),
        .size       (size),
        .sign_ext   (sign_ext),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .MEMADD     (MEMADD),
        .MEMDAT_OUT (MEMDAT_OUT),
        .MEMDAT_IN  (MEMDAT_IN),
        .MFA        (MFA),
        .MFC        (MFC),
        .READ_WRITE (READ_WRITE),
        .BYTE_EN    (BYTE_EN)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Absolute time guard so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] global timeout");
    end

    // Advance to 1 time unit after the next rising edge: outputs are sampled
    // and inputs changed there.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // ---------------- reference model (byte arithmetic) -------------------
    function automatic bit ref_misaligned(input logic [1:0] sz, input logic [7:0] a);
        if (sz == 2'b11) return 1'b1;
        return (int'(a) % (1 << sz)) != 0;
    endfunction

    function automatic logic [3:0] ref_byte_en(input logic [1:0] sz, input logic [7:0] a);
        int lane  = int'(a) % LANES;
        int bytes = 1 << sz;
        return 4'(((1 << bytes) - 1) << lane);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] w);
        if (sz == 2'b00) return 32'(w[7:0]) * 32'h0101_0101;
        if (sz == 2'b01) return 32'(w[15:0]) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] ref_rdata(input logic [1:0] sz, input logic sgn,
                                              input logic [7:0] a, input logic [31:0] m);
        int    lane  = int'(a) % LANES;
        int    nbits = 8 << sz;
        longint v;
        if (nbits >= 32) return m;
        v = (longint'(m) >> (8 * lane)) & ((64'd1 << nbits) - 1);
        if (sgn && v >= (64'd1 << (nbits - 1))) v = v - (64'd1 << nbits);
        return 32'(v);
    endfunction

    // ---------------- scenario drivers ------------------------------------
    // One complete aligned access from IDLE, with the memory answering MFC
    // after 'delay' ACCESS cycles. Request inputs are scrambled after
    // acceptance to show that the unit works from its latched copy.
    task automatic run_access(input logic r, input logic [1:0] sz, input logic sgn,
                              input logic [7:0] a, input logic [31:0] w,
                              input logic [31:0] m, input int delay, input string tag);
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        exp_be = ref_byte_en(sz, a);
        exp_wd = ref_wdata(sz, w);
        req = 1'b1; rw = r; size = sz; sign_ext = sgn; addr = a; wdata = w;
        tick();
        req = 1'b0; rw = ~r; sign_ext = ~sgn; addr = ~a; wdata = ~w; size = 2'b10;
        checks++; if (MFA !== 1'b1 || busy !== 1'b1) begin failures++; $display("[TB] FAIL %s accept: MFA=%0b busy=%0b expected 1 1", tag, MFA, busy); end
        checks++; if (MEMADD !== a) begin failures++; $display("[TB] FAIL %s MEMADD: got %h expected %h", tag, MEMADD, a); end
        checks++; if (BYTE_EN !== exp_be) begin failures++; $display("[TB] FAIL %s BYTE_EN: got %b expected %b", tag, BYTE_EN, exp_be); end
        checks++; if (READ_WRITE !== r) begin failures++; $display("[TB] FAIL %s READ_WRITE: got %0b expected %0b", tag, READ_WRITE, r); end
        if (r == 1'b0) begin
            checks++; if (MEMDAT_OUT !== exp_wd) begin failures++; $display("[TB] FAIL %s MEMDAT_OUT: got %h expected %h", tag, MEMDAT_OUT, exp_wd); end
        end
        for (int i = 0; i < delay; i++) begin
            MEMDAT_IN = $urandom;
            tick();
            checks++; if (MFA !== 1'b1 || done !== 1'b0 || MEMADD !== a) begin failures++; $display("[TB] FAIL %s wait%0d: MFA=%0b done=%0b MEMADD=%h expected 1 0 %h", tag, i, MFA, done, MEMADD, a); end
        end
        MFC = 1'b1; MEMDAT_IN = m;
        tick();
        if (r == 1'b1) model_rdata = ref_rdata(sz, sgn, a, m);
        checks++; if (done !== 1'b1 || MFA !== 1'b0) begin failures++; $display("[TB] FAIL %s complete: done=%0b MFA=%0b expected 1 0", tag, done, MFA); end
        checks++; if (rdata !== model_rdata) begin failures++; $display("[TB] FAIL %s rdata: got %h expected %h", tag, rdata, model_rdata); end
        MFC = 1'b0; MEMDAT_IN = $urandom;
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL %s release: done=%0b busy=%0b expected 0 0", tag, done, busy); end
    endtask

    // A rejected request: one err pulse, no bus cycle, rdata untouched.
    task automatic run_misaligned(input logic [1:0] sz, input logic [7:0] a, input string tag);
        req = 1'b1; rw = 1'b0; size = sz; addr = a; wdata = $urandom;
        tick();
        req = 1'b0;
        checks++; if (err !== 1'b1 || MFA !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL %s reject: err=%0b MFA=%0b busy=%0b done=%0b expected 1 0 0 0", tag, err, MFA, busy, done); end
        tick();
        checks++; if (err !== 1'b0 || MFA !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL %s after_reject: err=%0b MFA=%0b busy=%0b expected 0 0 0", tag, err, MFA, busy); end
        checks++; if (rdata !== model_rdata) begin failures++; $display("[TB] FAIL %s rdata_kept: got %h expected %h", tag, rdata, model_rdata); end
    endtask

    // ---------------- tests ------------------------------------------------
    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) tick();
        model_rdata = '0;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin failures++; $display("[TB] FAIL reset pulses: done=%0b err=%0b expected 0 0", done, err); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("[TB] FAIL reset rdata: got %h expected 0", rdata); end
        checks++; if (MEMADD !== 8'h0 || MEMDAT_OUT !== 32'h0) begin failures++; $display("[TB] FAIL reset bus: MEMADD=%h MEMDAT_OUT=%h expected 0 0", MEMADD, MEMDAT_OUT); end
        checks++; if (MFA !== 1'b0 || READ_WRITE !== 1'b1 || BYTE_EN !== 4'b0) begin failures++; $display("[TB] FAIL reset ctl: MFA=%0b READ_WRITE=%0b BYTE_EN=%b expected 0 1 0000", MFA, READ_WRITE, BYTE_EN); end
        Reset = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_release busy: got %0b expected 0", busy); end
    endtask

    task automatic test_directed();
        run_access(1'b0, 2'b10, 1'b0, 8'h10, 32'hDEAD_BEEF, 32'h0, 3, "word_write");
        run_access(1'b1, 2'b00, 1'b1, 8'h03, 32'h0, 32'h8011_2233, 1, "byte_read_sext");
        checks++; if (rdata !== 32'hFFFF_FF80) begin failures++; $display("[TB] FAIL byte_read_sext value: got %h expected ffffff80", rdata); end
        run_access(1'b1, 2'b00, 1'b0, 8'h03, 32'h0, 32'h8011_2233, 0, "byte_read_zext");
        checks++; if (rdata !== 32'h0000_0080) begin failures++; $display("[TB] FAIL byte_read_zext value: got %h expected 00000080", rdata); end
        run_access(1'b0, 2'b01, 1'b0, 8'h06, 32'h0000_ABCD, 32'h0, 2, "half_write");
        run_misaligned(2'b01, 8'h05, "half_misaligned");
        run_misaligned(2'b11, 8'h00, "illegal_size");
    endtask

    task automatic test_random();
        logic [1:0] sz;
        logic [7:0] a;
        for (int i = 0; i < 40; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 8'($urandom);
            if (ref_misaligned(sz, a))
                run_misaligned(sz, a, "rand_misaligned");
            else
                run_access(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom,
                           $urandom_range(0, 4), "rand_access");
        end
    endtask

    task automatic test_req_while_busy();
        int done_seen;
        req = 1'b1; rw = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 8'h20;
        tick();
        req = 1'b0;
        tick();
        req = 1'b1; addr = 8'h44; size = 2'b00; rw = 1'b0;
        tick();
        req = 1'b0;
        checks++; if (MEMADD !== 8'h20 || BYTE_EN !== 4'hF || READ_WRITE !== 1'b1 || MFA !== 1'b1) begin failures++; $display("[TB] FAIL busy_req held: MEMADD=%h BYTE_EN=%b RW=%0b MFA=%0b expected 20 1111 1 1", MEMADD, BYTE_EN, READ_WRITE, MFA); end
        MFC = 1'b1; MEMDAT_IN = 32'h1234_5678;
        tick();
        model_rdata = 32'h1234_5678;
        done_seen = (done === 1'b1) ? 1 : 0;
        checks++; if (rdata !== model_rdata) begin failures++; $display("[TB] FAIL busy_req rdata: got %h expected %h", rdata, model_rdata); end
        req = 1'b1; addr = 8'h08;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done === 1'b1) done_seen++;
            checks++; if (busy !== 1'b1 || MFA !== 1'b0) begin failures++; $display("[TB] FAIL release_hold%0d: busy=%0b MFA=%0b expected 1 0", i, busy, MFA); end
        end
        req = 1'b0; MFC = 1'b0;
        tick();
        if (done === 1'b1) done_seen++;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL release_exit busy: got %0b expected 0", busy); end
        checks++; if (done_seen != 1) begin failures++; $display("[TB] FAIL busy_req done_count: got %0d expected 1", done_seen); end
        checks++; if (MEMADD !== 8'h20) begin failures++; $display("[TB] FAIL busy_req MEMADD_after: got %h expected 20", MEMADD); end
    endtask

    task automatic test_back_to_back();
        req = 1'b1; rw = 1'b0; size = 2'b10; addr = 8'h30; wdata = 32'hCAFE_F00D;
        tick();
        req = 1'b0; MFC = 1'b1;
        tick();
        checks++; if (done !== 1'b1) begin failures++; $display("[TB] FAIL b2b first_done: got %0b expected 1", done); end
        MFC = 1'b0; req = 1'b1; rw = 1'b1; size = 2'b01; sign_ext = 1'b1; addr = 8'h36;
        tick();
        checks++; if (busy !== 1'b0 || MFA !== 1'b0) begin failures++; $display("[TB] FAIL b2b idle_entry: busy=%0b MFA=%0b expected 0 0", busy, MFA); end
        tick();
        req = 1'b0;
        checks++; if (MFA !== 1'b1 || MEMADD !== 8'h36 || READ_WRITE !== 1'b1 || BYTE_EN !== 4'b1100) begin failures++; $display("[TB] FAIL b2b second_accept: MFA=%0b MEMADD=%h RW=%0b BYTE_EN=%b expected 1 36 1 1100", MFA, MEMADD, READ_WRITE, BYTE_EN); end
        MFC = 1'b1; MEMDAT_IN = 32'h9ABC_0011;
        tick();
        model_rdata = ref_rdata(2'b01, 1'b1, 8'h36, 32'h9ABC_0011);
        checks++; if (done !== 1'b1 || rdata !== model_rdata) begin failures++; $display("[TB] FAIL b2b second_done: done=%0b rdata=%h expected 1 %h", done, rdata, model_rdata); end
        MFC = 1'b0;
        tick();
    endtask

    task automatic test_mfc_idle();
        MFC = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (busy !== 1'b0 || done !== 1'b0 || MFA !== 1'b0) begin failures++; $display("[TB] FAIL mfc_idle%0d: busy=%0b done=%0b MFA=%0b expected 0 0 0", i, busy, done, MFA); end
        end
        MFC = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        req = 1'b1; rw = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 8'h01;
        tick();
        req = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        model_rdata = '0;
        checks++; if (MFA !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin failures++; $display("[TB] FAIL reset_mid ctl: MFA=%0b busy=%0b done=%0b err=%0b expected 0 0 0 0", MFA, busy, done, err); end
        checks++; if (MEMADD !== 8'h0 || BYTE_EN !== 4'b0 || READ_WRITE !== 1'b1 || rdata !== 32'h0 || MEMDAT_OUT !== 32'h0) begin failures++; $display("[TB] FAIL reset_mid bus: MEMADD=%h BYTE_EN=%b RW=%0b rdata=%h MEMDAT_OUT=%h expected 00 0000 1 0 0", MEMADD, BYTE_EN, READ_WRITE, rdata, MEMDAT_OUT); end
        Reset = 1'b0; MFC = 1'b1;
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_mid late_mfc: done=%0b busy=%0b expected 0 0", done, busy); end
        MFC = 1'b0;
        tick();
        run_access(1'b1, 2'b01, 1'b1, 8'h02, 32'h0, 32'h8001_7FFF, 1, "after_reset");
    endtask

    task automatic test_timeout();
        int highs;
        logic [31:0] kept;
        kept = model_rdata;
        req = 1'b1; rw = 1'b1; size = 2'b10; addr = 8'h40; MFC = 1'b0;
        tick();
        req = 1'b0;
`ifdef MAU_TIMEOUT_EN
        highs = 0;
        while (MFA === 1'b1 && highs < 200) begin
            highs++;
            tick();
        end
        checks++; if (highs != 15) begin failures++; $display("[TB] FAIL timeout mfa_cycles: got %0d expected 15", highs); end
        checks++; if (err !== 1'b1 || done !== 1'b0) begin failures++; $display("[TB] FAIL timeout pulse: err=%0b done=%0b expected 1 0", err, done); end
        MFC = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b1 || MFA !== 1'b0) begin failures++; $display("[TB] FAIL timeout late_mfc%0d: done=%0b err=%0b busy=%0b MFA=%0b expected 0 0 1 0", i, done, err, busy, MFA); end
        end
        MFC = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || rdata !== kept) begin failures++; $display("[TB] FAIL timeout exit: busy=%0b rdata=%h expected 0 %h", busy, rdata, kept); end
`else
        highs = 0;
        for (int i = 0; i < 100; i++) begin
            if (MFA === 1'b1 && err === 1'b0) highs++;
            tick();
        end
        checks++; if (highs != 100) begin failures++; $display("[TB] FAIL no_watchdog mfa_cycles: got %0d expected 100", highs); end
        MFC = 1'b1; MEMDAT_IN = 32'h0BAD_CAFE;
        tick();
        model_rdata = 32'h0BAD_CAFE;
        checks++; if (done !== 1'b1 || rdata !== model_rdata) begin failures++; $display("[TB] FAIL no_watchdog finish: done=%0b rdata=%h expected 1 %h (prev %h)", done, rdata, model_rdata, kept); end
        MFC = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL no_watchdog exit busy: got %0b expected 0", busy); end
`endif
    endtask

    initial begin
        Reset = 1'b1; req = 1'b0; rw = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = '0; wdata = '0; MEMDAT_IN = '0; MFC = 1'b0;
        model_rdata = '0;
        $display("[TB] starting mem_access_unit bench");
        test_reset();
        test_directed();
        test_random();
        test_req_while_busy();
        test_back_to_back();
        test_mfc_idle();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
